// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared FSM encodings and BCD digit limit for the operand loader
package bcd_pkg;

   typedef enum logic [1:0] {
      GET_X = 2'b00,
      GET_Y = 2'b01,
      READY = 2'b10
   } state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;

   function automatic logic is_bcd(input logic [3:0] d);
      return d <= BCD_MAX;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-flop synchronizer, counter debounce and press pulse for one active-low key
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             level;
   logic             level_prev;
   logic             armed;
   logic [1:0]       fill;
   logic [CNT_W-1:0] cnt;
   logic             expire;

   assign expire = (sync2 != level) && (cnt == CNT_LAST);

   // armed only after a genuine released sample is seen, so a key held through reset never fires
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1      <= 1'b1;
         sync2      <= 1'b1;
         level      <= 1'b1;
         level_prev <= 1'b1;
         cnt        <= '0;
         fill       <= 2'b00;
         armed      <= 1'b0;
         press      <= 1'b0;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
         fill  <= {fill[0], 1'b1};
         if (fill[1] && sync2) begin
            armed <= 1'b1;
         end
         if (sync2 == level) begin
            cnt <= '0;
         end else if (expire) begin
            cnt   <= '0;
            level <= sync2;
         end else begin
            cnt <= cnt + 1'b1;
         end
         level_prev <= level;
         press      <= armed & level_prev & ~level;
      end
   end

endmodule

// File: rtl/bcd_operand_loader.sv
// rtl/bcd_operand_loader.sv - debounced keypad entry of two BCD operands and carry-in for a BCD adder
module bcd_operand_loader
   import bcd_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic [3:0] digit_in,
   input  logic       cin_in,
   input  logic       load_n,
   input  logic       clear_n,
   output logic [3:0] X,
   output logic [3:0] Y,
   output logic       cin,
   output logic       valid,
   output logic       err,
   output logic [1:0] state
);

   state_t     state_q;
   state_t     state_d;
   logic [3:0] x_d;
   logic [3:0] y_d;
   logic       cin_d;
   logic       valid_d;
   logic       err_d;
   logic       load_p;
   logic       clear_p;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_load_key (
      .clk   (Clock),
      .rst_n (Resetn),
      .key_n (load_n),
      .press (load_p)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clear_key (
      .clk   (Clock),
      .rst_n (Resetn),
      .key_n (clear_n),
      .press (clear_p)
   );

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= GET_X;
         X       <= '0;
         Y       <= '0;
         cin     <= 1'b0;
         valid   <= 1'b0;
         err     <= 1'b0;
      end else begin
         state_q <= state_d;
         X       <= x_d;
         Y       <= y_d;
         cin     <= cin_d;
         valid   <= valid_d;
         err     <= err_d;
      end
   end

   // a rejected digit only raises err; clear always wins over a simultaneous load
   always_comb begin
      state_d = state_q;
      x_d     = X;
      y_d     = Y;
      cin_d   = cin;
      valid_d = valid;
      err_d   = err;
      if (clear_p) begin
         state_d = GET_X;
         x_d     = '0;
         y_d     = '0;
         cin_d   = 1'b0;
         valid_d = 1'b0;
         err_d   = 1'b0;
      end else begin
         case (state_q)
            GET_X: begin
               if (load_p) begin
                  if (is_bcd(digit_in)) begin
                     x_d     = digit_in;
                     err_d   = 1'b0;
                     state_d = GET_Y;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            GET_Y: begin
               if (load_p) begin
                  if (is_bcd(digit_in)) begin
                     y_d     = digit_in;
                     cin_d   = cin_in;
                     err_d   = 1'b0;
                     valid_d = 1'b1;
                     state_d = READY;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            READY: begin
               if (load_p) begin
                  if (is_bcd(digit_in)) begin
                     x_d     = digit_in;
                     valid_d = 1'b0;
                     err_d   = 1'b0;
                     state_d = GET_Y;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            default: state_d = GET_X;
         endcase
      end
   end

   assign state = state_q;

endmodule

// File: doc/bcd_operand_loader.md
BCD_OPERAND_LOADER -- requirements
Module: bcd_operand_loader

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, giving the consecutive stable cycles a key must hold before its level is accepted.
REQ-002 SHALL have parameter CNT_W, default 16, giving the debounce counter width; it SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 SHALL have port Clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Resetn, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port digit_in, input, 4, the candidate BCD digit (board switches).
REQ-006 SHALL have port cin_in, input, 1, the candidate carry-in.
REQ-007 SHALL have port load_n, input, 1, the raw active-low load pushbutton (asynchronous, bouncy).
REQ-008 SHALL have port clear_n, input, 1, the raw active-low clear pushbutton (asynchronous, bouncy).
REQ-009 SHALL have ports X and Y, output, 4 each, the registered operands feeding the downstream BCD adder.
REQ-010 SHALL have port cin, output, 1, the registered carry-in to the adder.
REQ-011 SHALL have port valid, output, 1; high means X, Y and cin form a complete, checked operand set.
REQ-012 SHALL have port err, output, 1, a sticky flag meaning the last load attempt was rejected as non-BCD.
REQ-013 SHALL have port state, output, 2, the current FSM state for LED display.

Function
REQ-014 load_n and clear_n SHALL each pass through a 2-flop synchronizer before any other use.
REQ-015 Debounce SHALL use a counter that clears whenever the synchronized level equals the debounced level.
- It increments while the two levels differ.
- When it reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips and the counter clears.
REQ-016 On each debounced high-to-low transition, a registered single-cycle pulse (load_p or clear_p) SHALL be generated.
- No pulse on release.
- Holding the key produces exactly one pulse.
REQ-017 The FSM SHALL have three states: GET_X=2'b00, GET_Y=2'b01, READY=2'b10; encoding 2'b11 is illegal and SHALL recover to GET_X on the next edge.
REQ-018 In GET_X, load_p with digit_in<=9 SHALL set X<=digit_in, err<=0, next state GET_Y.
REQ-019 In GET_Y, load_p with digit_in<=9 SHALL set Y<=digit_in, cin<=cin_in, err<=0, valid<=1, next state READY.
REQ-020 In READY, load_p with digit_in<=9 SHALL set X<=digit_in, valid<=0, err<=0, next state GET_Y; Y and cin keep their old values.
REQ-021 In any state, load_p with digit_in>9 SHALL set err<=1 and leave state, X, Y, cin and valid unchanged.
REQ-022 clear_p SHALL, in any state, set X=0, Y=0, cin=0, valid=0, err=0 and state GET_X.
REQ-023 clear_p SHALL take priority over load_p in the same cycle.
REQ-024 Register updates SHALL occur on the edge on which load_p/clear_p is high, giving one cycle from pulse to output.
REQ-025 X, Y and cin SHALL change only per REQ-018 to REQ-022; switch changes without a load_p SHALL have no effect.
REQ-026 Total latency from a stable raw press to output update SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 (pulse) + 1 cycles, within ±1 cycle.

Reset
REQ-027 While Resetn=0, the block SHALL hold X=0, Y=0, cin=0, valid=0, err=0, state=GET_X.
- Synchronizers and debounced levels are held at 1 (released); counters are held at 0.
REQ-028 Reset asserted mid-debounce or mid-entry SHALL discard the pending press.
- No pulse is generated on release of reset, even if a key is still held.

Structure
REQ-029 The state encodings and the constant BCD_MAX=9 SHALL live in the shared package bcd_pkg.
REQ-030 Synchronizer, debounce and press-pulse logic SHALL form one sub-module, key_debounce, instantiated twice (load and clear).

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Reset, then load 3, load 7 with cin_in=1 -> X=3, Y=7, cin=1, valid=1, state=2'b10.
REQ-032 In GET_X, load digit_in=4'hC -> err=1, state=2'b00, X=0; then load 5 -> err=0, X=5, state=2'b01.
REQ-033 Raw load_n bouncing 1-0-1-0 at 2-cycle intervals, then held low for 10 cycles -> exactly one update; a 3-cycle glitch -> none.
REQ-034 From READY (X=3, Y=7), load 9 -> X=9, Y=7, valid=0, state=2'b01.
REQ-035 load_p and clear_p coincide -> all outputs 0, state GET_X; Resetn pulsed low mid-debounce -> no update after release.
